instr_fetch: RTL



---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 14 +
 rtl/instr_fetch_sat_counter.sv | 25 ++
 rtl/instr_fetch.sv | 84 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths; the IF/ID struct is also consumed by decode.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INSN_W = 16;
  localparam logic [INSN_W-1:0] HALT_INSN = 16'h0000;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSN_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } ifid_t;

endpackage

// File: rtl/instr_fetch_if.sv
// IF/ID valid/ready handshake between fetch (master) and decode (slave).
interface instr_fetch_if
  import fetch_pkg::*;
  ();

  logic              valid;
  logic              ready;
  logic [INSN_W-1:0] instr;
  logic [ADDR_W-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);

endinterface

// File: rtl/instr_fetch_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the combinational ROM and holds the IF/ID register.
//   state | meaning
//   RUN   | fetching, IF/ID loaded whenever empty or being accepted
//   HALT  | halt word captured; PC frozen until a redirect
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC_P  = RESET_PC,
  parameter logic [INSN_W-1:0] HALT_INSN_P = HALT_INSN,
  parameter bit                HALT_EN     = 1'b1,
  parameter int                CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSN_W-1:0]  rom_data,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  instr_fetch_if.master      out,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic              valid_q, valid_d;
  logic              load;
  logic              accept;

  assign load   = !valid_q || out.ready;
  assign accept = valid_q && out.ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    valid_d = valid_q;
    if (branch_valid) begin
      // Flush drops the IF/ID word even if decode takes it this cycle.
      pc_d    = branch_target;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (load) begin
        ifid_d.instr = rom_data;
        ifid_d.pc    = pc_q;
        valid_d      = 1'b1;
        if (HALT_EN && (rom_data == HALT_INSN_P)) state_d = HALT;
        else                                      pc_d    = pc_q + ADDR_W'(1);
      end
    end else begin
      if (out.ready) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC_P;
      ifid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .count (fetch_count)
  );

  assign rom_addr  = pc_q;
  assign out.valid = valid_q;
  assign out.instr = ifid_q.instr;
  assign out.pc    = ifid_q.pc;
  assign halted    = (state_q == HALT);

endmodule
